// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Ex operand source select
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WR  = 2'b10;

  // Multiply/divide sequencer state
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Bypass select for one Ex source; Mem wins because it holds the newer value, r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wr_rd, input logic wr_we);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wr_we && (wr_rd != 5'd0) && (wr_rd == src)) begin
      return FWD_WR;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_sequencer.sv
// Occupancy tracker for the multi-cycle multiply/divide unit.
module md_sequencer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam logic [3:0] LatM1 = 4'(MD_LAT - 1);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  // State, countdown and done-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state: a start while busy is ignored since ID blocks MD ops during BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = LatM1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy = (state_q == BUSY);
  assign md_done = done_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, bypass selection and stall/flush accounting for the five-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_use,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wr_rd,
  input  logic             mem_reg_write,
  input  logic             wr_reg_write,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             lu, mh, stall;
  logic             ex_writes_unused;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  md_sequencer #(
    .MD_LAT (MD_LAT)
  ) u_md_sequencer (
    .clk      (clk),
    .rst      (rst),
    .md_start (ex_md_start),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  // A load is the only Ex-stage producer that cannot be bypassed; ex_reg_write is not needed here.
  assign ex_writes_unused = ex_reg_write;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  assign mh = md_busy && id_md_use;
  // A taken branch squashes the stalled instruction, so it overrides both hazards
  assign stall = (lu || mh) && !ex_branch_taken;

  // Stage enables and flushes
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Ex operand bypass selects
  always_comb begin
    fwd_a = fwd_sel(ex_rs, mem_rd, mem_reg_write, wr_rd, wr_reg_write);
    fwd_b = fwd_sel(ex_rt, mem_rd, mem_reg_write, wr_rd, wr_reg_write);
  end

  // Performance counters, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_branch_taken) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LAT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wr_rd;
  logic       id_use_rs, id_use_rt, id_md_use;
  logic       ex_reg_write, ex_mem_read, ex_md_start, ex_branch_taken;
  logic       mem_reg_write, wr_reg_write;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       md_busy, md_done;
  logic [3:0] stall_cnt, flush_cnt;

  int ntests = 0;
  int nfail  = 0;

  pipe_hazard_ctrl #(
    .MD_LAT (4),
    .CNT_W  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_md_use       (id_md_use),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_md_start     (ex_md_start),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .wr_rd           (wr_rd),
    .mem_reg_write   (mem_reg_write),
    .wr_reg_write    (wr_reg_write),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wr_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_md_use = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_md_start = 0; ex_branch_taken = 0;
    mem_reg_write = 0; wr_reg_write = 0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    ntests++;
    if ({md_busy, md_done, stall_cnt, flush_cnt} !== 10'b0) begin
      nfail++;
      $display("FAIL reset_regs: busy=%b done=%b stall=%0d flush=%0d, required all 0",
               md_busy, md_done, stall_cnt, flush_cnt);
    end
    ntests++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush, fwd_a, fwd_b} !== 8'b1100_0000) begin
      nfail++;
      $display("FAIL reset_comb: pc=%b ifw=%b iff=%b idf=%b fa=%b fb=%b, required 1 1 0 0 00 00",
               pc_write, if_id_write, if_id_flush, id_ex_flush, fwd_a, fwd_b);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    // lw r5 in Ex, add using r5 (rs) in ID
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    #1;
    ntests++;
    if ({pc_write, if_id_write, id_ex_flush, if_id_flush} !== 4'b0010) begin
      nfail++;
      $display("FAIL lu_rs_stall: pc=%b ifw=%b idf=%b iff=%b, required 0 0 1 0",
               pc_write, if_id_write, id_ex_flush, if_id_flush);
    end
    step();
    ntests++;
    if (stall_cnt !== 4'd1) begin
      nfail++;
      $display("FAIL lu_stall_cnt: got %0d, required 1", stall_cnt);
    end
    // Load now in Mem, consumer in Ex
    clear_inputs();
    mem_rd = 5; mem_reg_write = 1; ex_rs = 5;
    #1;
    ntests++;
    if (pc_write !== 1'b1 || fwd_a !== 2'b01) begin
      nfail++;
      $display("FAIL lu_release_fwd: pc=%b fa=%b, required 1 01", pc_write, fwd_a);
    end
    step();
    // Consumer reaches Ex one cycle later still: load result now in Wr
    clear_inputs();
    wr_rd = 5; wr_reg_write = 1; ex_rs = 5;
    #1;
    ntests++;
    if (fwd_a !== 2'b10) begin
      nfail++;
      $display("FAIL lu_fwd_wr: fa=%b, required 10", fwd_a);
    end
    // Load to r0 never stalls
    clear_inputs();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    #1;
    ntests++;
    if (pc_write !== 1'b1 || id_ex_flush !== 1'b0) begin
      nfail++;
      $display("FAIL lu_r0: pc=%b idf=%b, required 1 0", pc_write, id_ex_flush);
    end
    step();
    // rt hazard stalls only when rt is actually read
    clear_inputs();
    ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1;
    #1;
    ntests++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
      nfail++;
      $display("FAIL lu_rt_stall: pc=%b ifw=%b, required 0 0", pc_write, if_id_write);
    end
    step();
    id_use_rt = 0;
    #1;
    ntests++;
    if (pc_write !== 1'b1) begin
      nfail++;
      $display("FAIL lu_rt_unused: pc=%b, required 1", pc_write);
    end
    ntests++;
    if (stall_cnt !== 4'd2) begin
      nfail++;
      $display("FAIL lu_stall_cnt2: got %0d, required 2", stall_cnt);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    ex_rs = 3; ex_rt = 3; mem_rd = 3; wr_rd = 3; mem_reg_write = 1; wr_reg_write = 1;
    #1;
    ntests++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      nfail++;
      $display("FAIL fwd_mem_prio: fa=%b fb=%b, required 01 01", fwd_a, fwd_b);
    end
    mem_reg_write = 0;
    #1;
    ntests++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      nfail++;
      $display("FAIL fwd_wr: fa=%b fb=%b, required 10 10", fwd_a, fwd_b);
    end
    mem_reg_write = 1; ex_rs = 0; ex_rt = 0; mem_rd = 0; wr_rd = 0;
    #1;
    ntests++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      nfail++;
      $display("FAIL fwd_r0: fa=%b fb=%b, required 00 00", fwd_a, fwd_b);
    end
    ex_rs = 3; ex_rt = 7; mem_rd = 7; wr_rd = 3;
    #1;
    ntests++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
      nfail++;
      $display("FAIL fwd_split: fa=%b fb=%b, required 10 01", fwd_a, fwd_b);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_branch_vs_stall();
    ex_mem_read = 1; ex_rd = 4; id_rs = 4; id_use_rs = 1; ex_branch_taken = 1;
    #1;
    ntests++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111) begin
      nfail++;
      $display("FAIL branch_override: pc=%b ifw=%b iff=%b idf=%b, required 1 1 1 1",
               pc_write, if_id_write, if_id_flush, id_ex_flush);
    end
    step();
    clear_inputs();
    ntests++;
    if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin
      nfail++;
      $display("FAIL branch_counts: stall=%0d flush=%0d, required 2 1", stall_cnt, flush_cnt);
    end
    step();
  endtask

  task automatic test_md_latency();
    // cycle t
    ex_md_start = 1;
    #1;
    ntests++;
    if (md_busy !== 1'b0) begin
      nfail++;
      $display("FAIL md_idle_at_start: busy=%b, required 0", md_busy);
    end
    step();
    // cycles t+1..t+3: mfhi waits in ID
    ex_md_start = 0; id_md_use = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      ntests++;
      if (md_busy !== 1'b1 || md_done !== 1'b0 || pc_write !== 1'b0 || id_ex_flush !== 1'b1) begin
        nfail++;
        $display("FAIL md_busy_t%0d: busy=%b done=%b pc=%b idf=%b, required 1 0 0 1",
                 i, md_busy, md_done, pc_write, id_ex_flush);
      end
      step();
    end
    // cycle t+4: result valid, mfhi released
    #1;
    ntests++;
    if (md_busy !== 1'b0 || md_done !== 1'b1 || pc_write !== 1'b1) begin
      nfail++;
      $display("FAIL md_done_t4: busy=%b done=%b pc=%b, required 0 1 1", md_busy, md_done, pc_write);
    end
    ntests++;
    if (stall_cnt !== 4'd5 || flush_cnt !== 4'd1) begin
      nfail++;
      $display("FAIL md_stall_cnt: stall=%0d flush=%0d, required 5 1", stall_cnt, flush_cnt);
    end
    step();
    clear_inputs();
    #1;
    ntests++;
    if (md_done !== 1'b0 || md_busy !== 1'b0) begin
      nfail++;
      $display("FAIL md_done_pulse: done=%b busy=%b, required 0 0", md_done, md_busy);
    end
    step();
  endtask

  task automatic test_reset_mid_busy();
    ex_md_start = 1;
    step();
    ex_md_start = 0;
    step();
    // second busy cycle: abort with async reset
    rst = 1'b1;
    #1;
    ntests++;
    if (md_busy !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      nfail++;
      $display("FAIL rst_busy_clear: busy=%b stall=%0d flush=%0d, required 0 0 0",
               md_busy, stall_cnt, flush_cnt);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      ntests++;
      if (md_done !== 1'b0 || md_busy !== 1'b0) begin
        nfail++;
        $display("FAIL rst_no_done_%0d: done=%b busy=%b, required 0 0", i, md_done, md_busy);
      end
    end
  endtask

  task automatic test_counter_wrap();
    ex_mem_read = 1; ex_rd = 6; id_rt = 6; id_use_rt = 1;
    for (int i = 0; i < 17; i++) step();
    clear_inputs();
    #1;
    ntests++;
    if (stall_cnt !== 4'd1) begin
      nfail++;
      $display("FAIL stall_wrap: got %0d, required 1", stall_cnt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_vs_stall();
    test_md_latency();
    test_reset_mid_busy();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-sequencing controller for the five-stage PipeLine_CPU (IF, ID, Ex, Mem, Wr). Each cycle it decides which stages advance, which are bubbled or flushed, and which bypass path feeds each Ex operand. It also sequences a multi-cycle multiply/divide unit with a small FSM, and keeps stall and flush performance counters. It sits beside the stage registers and drives their write-enable and flush inputs.

## Interface
- MD_LAT, 4, cycles a multiply/divide occupies the MD unit (2..15)
- CNT_W, 16, width of performance counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the ID-stage instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction reads that source
- id_md_use  in  1  ID instruction is mult/div/mfhi/mflo
- ex_rs, ex_rt  in  5 each  source registers of the Ex-stage instruction
- ex_rd  in  5  Ex destination
- ex_reg_write, ex_mem_read  in  1 each  Ex writes a register / is a load
- ex_md_start  in  1  mult/div in Ex this cycle
- ex_branch_taken  in  1  branch/jump resolved taken in Ex
- mem_rd, wr_rd  in  5 each  Mem/Wr destinations
- mem_reg_write, wr_reg_write  in  1 each  Mem/Wr write a register
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID register may load
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  load a bubble into ID/EX
- fwd_a, fwd_b  out  2 each  Ex operand select: 00 regfile, 01 Mem result, 10 Wr result
- md_busy  out  1  MD unit occupied
- md_done  out  1  one-cycle pulse when the MD result is valid in HI/LO
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Load-use hazard (lu): ex_mem_read & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- MD hazard (mh): md_busy & id_md_use.
- stall = (lu | mh) & ~ex_branch_taken.
- On stall: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
- On ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1.
- Branch overrides both hazard types, because the stalled instruction is on the wrong path.
- Otherwise pc_write=if_id_write=1 and both flushes are 0.
- Forwarding for operand A (B is identical with ex_rt):
  - 01 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rs.
  - else 10 if wr_reg_write & wr_rd≠0 & wr_rd==ex_rs.
  - else 00.
  - Mem has priority over Wr because it holds the newer value.
- r0 never forwards and never causes a hazard.
- MD FSM has two states, IDLE and BUSY, with counter cnt (4 bits).
  - IDLE & ex_md_start → BUSY, cnt=MD_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt==1, next state is IDLE and md_done is registered high for the following cycle.
  - ex_md_start while BUSY is ignored. It cannot occur legally because mh blocks MD instructions in ID.
  - A branch flush does not abort BUSY: the MD instruction in flight is architecturally older than the branch.
- md_busy = (state==BUSY).
- Counters:
  - stall_cnt increments on every cycle where stall=1.
  - flush_cnt increments on every cycle where ex_branch_taken=1.
  - Both wrap modulo 2^CNT_W.

## Timing
- All control and forwarding outputs are combinational from the inputs and the current state. They are valid within the same cycle and are sampled by the stage registers on the next rising edge of clk.
- md_busy, md_done and the counters are registered.
- MD latency: with ex_md_start high in cycle t, md_busy is high in t+1..t+MD_LAT-1 and md_done pulses in cycle t+MD_LAT. An mfhi in ID is released in that same cycle t+MD_LAT.
- A load-use stall inserts exactly one bubble. The next cycle the load is in Mem, the consumer re-evaluates, and it forwards from Wr one cycle later.
- Reset value of every registered output: state IDLE, cnt=0, md_busy=0, md_done=0, stall_cnt=0, flush_cnt=0.
- Combinational outputs with all inputs 0 after reset: pc_write=1, if_id_write=1, both flushes 0, fwd_a=fwd_b=00.
- Reset asserted mid-BUSY: the operation is abandoned and no md_done pulse is produced.

## Structure
- Shared package holds:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WR=2'b10.
  - MD state encoding: IDLE=1'b0, BUSY=1'b1.
- One sub-module, md_sequencer, contains the MD FSM, its counter and md_done.
- Hazard detection, forwarding and the counters stay in the top level, pipe_hazard_ctrl.

## Test plan
- Load-use: ex lw rd=5 with ex_mem_read=1; ID add with rs=5 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1.
- Forwarding priority: ex_rs=ex_rt=3, mem_rd=3, wr_rd=3, both reg_write=1 → fwd_a=fwd_b=01. Drop mem_reg_write → both 10. Set all rd=0 → both 00.
- Branch vs stall: lu condition and ex_branch_taken=1 together → pc_write=1, if_id_flush=1, id_ex_flush=1; stall_cnt unchanged; flush_cnt +1.
- MD latency with MD_LAT=4: ex_md_start at cycle 10 → md_busy high in cycles 11–13; md_done high in cycle 14 only; mfhi in ID stalls in cycles 11–13 (stall_cnt +3) and is released in cycle 14.
- Reset mid-BUSY: assert rst in cycle 12 of the previous scenario → md_busy=0 immediately, no md_done afterwards, counters read 0.
- Counter wrap with CNT_W=4: 17 consecutive stall cycles → stall_cnt=1.
